nodf_module_status_tracker: RTL and testbench

- Cycle-accurate status tracker for one non-dataflow HLS block-level handshake (ap_start/ap_ready/ap_done/ap_continue).
- Counts accepted transactions, measures per-transaction latency and start-to-start interval, and accumulates stall cycles.
- Reports the monitored module's state.
- Sits beside each monitored HLS instance in the simulation/debug hierarchy; purely observational, never drives the monitored module.

---
 rtl/nodf_module_status_tracker.sv | 236 +++++++++++++++++++++++
 tb/tb_nodf_module_status_tracker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/nodf_module_status_tracker.sv
// nodf_module_status_tracker
// Passive observer for one HLS block-level handshake (ap_start/ap_ready/ap_done/ap_continue).
// Counts transactions, measures latency and start-to-start interval, accumulates stall cycles
// and reports the monitored module's state. It never drives the monitored module.
module nodf_module_status_tracker #(
    parameter int CNT_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         ap_start,
    input  logic                         ap_ready,
    input  logic                         ap_done,
    input  logic                         ap_continue,
    input  logic                         finish,
    output logic [1:0]                   state,
    output logic [CNT_W-1:0]             cycle_cnt,
    output logic [CNT_W-1:0]             start_cnt,
    output logic [CNT_W-1:0]             done_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
    output logic [CNT_W-1:0]             last_latency,
    output logic [CNT_W-1:0]             min_latency,
    output logic [CNT_W-1:0]             max_latency,
    output logic [CNT_W-1:0]             last_interval,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic                         overflow,
    output logic                         underflow,
    output logic                         finished
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_STALL    = 2'd2,
        ST_FINISHED = 2'd3
    } state_t;

    // Counters never wrap: once at all ones they stay there.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Registered state and its next-state companions
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cycleCnt_q, cycleCnt_d;
    logic [CNT_W-1:0]   startCnt_q, startCnt_d;
    logic [CNT_W-1:0]   doneCnt_q, doneCnt_d;
    logic [CNT_W-1:0]   lastLat_q, lastLat_d;
    logic [CNT_W-1:0]   minLat_q, minLat_d;
    logic [CNT_W-1:0]   maxLat_q, maxLat_d;
    logic [CNT_W-1:0]   lastInt_q, lastInt_d;
    logic [CNT_W-1:0]   stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0]   prevStartTs_q, prevStartTs_d;
    logic               havePrevStart_q, havePrevStart_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               finished_q, finished_d;

    // Timestamp FIFO: start times of transactions that have not completed yet
    logic [CNT_W-1:0]   fifoMem_q [DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [OCC_W-1:0]   count_q, count_d;

    // Decoded handshake events and FIFO control
    logic               active;
    logic               startEv;
    logic               doneEv;
    logic               stallCond;
    logic               fifoEmpty;
    logic               fifoFull;
    logic               bypass;
    logic               doPop;
    logic               doPush;
    logic               overflowEv;
    logic               underflowEv;
    logic               haveLatency;
    logic [CNT_W-1:0]   latency;

    // Decode the handshake into start/done events; once finished every input is ignored.
    // A done with an empty FIFO but a simultaneous start completes that very start (bypass).
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    always_comb begin
        active      = !finished_q;
        startEv     = active && ap_start && ap_ready;
        doneEv      = active && ap_done && ap_continue;
        stallCond   = active && ap_done && !ap_continue;
        fifoEmpty   = (count_q == '0);
        fifoFull    = (count_q == FULL_OCC);
        bypass      = startEv && doneEv && fifoEmpty;
        doPop       = doneEv && !fifoEmpty;
        doPush      = startEv && !bypass && (!fifoFull || doPop);
        overflowEv  = startEv && fifoFull && !doPop;
        underflowEv = doneEv && fifoEmpty && !startEv;
        haveLatency = doPop || bypass;
        latency     = bypass ? '0 : (cycleCnt_q - fifoMem_q[rdPtr_q]);
    end

    // FIFO pointer and occupancy update; occupancy is what drives the outstanding output.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        count_d = count_q + OCC_W'(doPush) - OCC_W'(doPop);
    end

    // Statistics update: counters, latency min/max, start interval and sticky error flags.
    // Everything holds its value once finished, which freezes the whole report.
    always_comb begin
        cycleCnt_d      = cycleCnt_q;
        startCnt_d      = startCnt_q;
        doneCnt_d       = doneCnt_q;
        lastLat_d       = lastLat_q;
        minLat_d        = minLat_q;
        maxLat_d        = maxLat_q;
        lastInt_d       = lastInt_q;
        stallCnt_d      = stallCnt_q;
        prevStartTs_d   = prevStartTs_q;
        havePrevStart_d = havePrevStart_q;
        overflow_d      = overflow_q || overflowEv;
        underflow_d     = underflow_q || underflowEv;
        finished_d      = finished_q || finish;

        if (active) begin
            cycleCnt_d = satInc(cycleCnt_q);
        end
        if (stallCond) begin
            stallCnt_d = satInc(stallCnt_q);
        end
        if (startEv) begin
            startCnt_d      = satInc(startCnt_q);
            lastInt_d       = havePrevStart_q ? (cycleCnt_q - prevStartTs_q) : '0;
            prevStartTs_d   = cycleCnt_q;
            havePrevStart_d = 1'b1;
        end
        if (doneEv) begin
            doneCnt_d = satInc(doneCnt_q);
        end
        if (haveLatency) begin
            lastLat_d = latency;
            if (latency < minLat_q) begin
                minLat_d = latency;
            end
            if (latency > maxLat_q) begin
                maxLat_d = latency;
            end
        end
    end

    // Next reported state: FINISHED absorbs, then a blocked done (STALL), then any pending
    // or requested work (BUSY), else IDLE. Uses current inputs and next occupancy.
    always_comb begin
        state_d = ST_IDLE;
        if (finished_q || finish) begin
            state_d = ST_FINISHED;
        end else if (ap_done && !ap_continue) begin
            state_d = ST_STALL;
        end else if ((count_d != '0) || ap_start) begin
            state_d = ST_BUSY;
        end
    end

    // State register with synchronous reset; reset empties the FIFO and clears the report.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            cycleCnt_q      <= '0;
            startCnt_q      <= '0;
            doneCnt_q       <= '0;
            lastLat_q       <= '0;
            minLat_q        <= CNT_MAX;
            maxLat_q        <= '0;
            lastInt_q       <= '0;
            stallCnt_q      <= '0;
            prevStartTs_q   <= '0;
            havePrevStart_q <= 1'b0;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
            finished_q      <= 1'b0;
            wrPtr_q         <= '0;
            rdPtr_q         <= '0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            cycleCnt_q      <= cycleCnt_d;
            startCnt_q      <= startCnt_d;
            doneCnt_q       <= doneCnt_d;
            lastLat_q       <= lastLat_d;
            minLat_q        <= minLat_d;
            maxLat_q        <= maxLat_d;
            lastInt_q       <= lastInt_d;
            stallCnt_q      <= stallCnt_d;
            prevStartTs_q   <= prevStartTs_d;
            havePrevStart_q <= havePrevStart_d;
            overflow_q      <= overflow_d;
            underflow_q     <= underflow_d;
            finished_q      <= finished_d;
            wrPtr_q         <= wrPtr_d;
            rdPtr_q         <= rdPtr_d;
            count_q         <= count_d;
        end
    end

    // Timestamp storage; contents are only meaningful below the occupancy, so no reset needed.
    always_ff @(posedge clock) begin
        if (!reset && doPush) begin
            fifoMem_q[wrPtr_q] <= cycleCnt_q;
        end
    end

    assign state         = state_q;
    assign cycle_cnt     = cycleCnt_q;
    assign start_cnt     = startCnt_q;
    assign done_cnt      = doneCnt_q;
    assign outstanding   = count_q;
    assign last_latency  = lastLat_q;
    assign min_latency   = minLat_q;
    assign max_latency   = maxLat_q;
    assign last_interval = lastInt_q;
    assign stall_cnt     = stallCnt_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;
    assign finished      = finished_q;

endmodule

// File: tb/tb_nodf_module_status_tracker.sv
// Testbench for nodf_module_status_tracker: table-driven vectors plus hand-written
// sequences for reset/idle, stall and finish behaviour.
module tb_nodf_module_status_tracker;

    localparam int CNT_W = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] F = 32'hFFFF_FFFF;

    logic                        clock;
    logic                        reset;
    logic                        ap_start;
    logic                        ap_ready;
    logic                        ap_done;
    logic                        ap_continue;
    logic                        finish;
    logic [1:0]                  state;
    logic [CNT_W-1:0]            cycle_cnt;
    logic [CNT_W-1:0]            start_cnt;
    logic [CNT_W-1:0]            done_cnt;
    logic [$clog2(DEPTH+1)-1:0]  outstanding;
    logic [CNT_W-1:0]            last_latency;
    logic [CNT_W-1:0]            min_latency;
    logic [CNT_W-1:0]            max_latency;
    logic [CNT_W-1:0]            last_interval;
    logic [CNT_W-1:0]            stall_cnt;
    logic                        overflow;
    logic                        underflow;
    logic                        finished;

    int testsRun = 0;
    int failCount = 0;

    typedef struct {
        logic [31:0] rst, s, rd, d, c, f;
        logic [31:0] eSt, eCyc, eSc, eDc, eOut, eLast, eMin, eMax, eInt, eStall, eOvf, eUnf, eFin;
    } vec_t;

    vec_t vecs[$];

    nodf_module_status_tracker #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .ap_start(ap_start),
        .ap_ready(ap_ready),
        .ap_done(ap_done),
        .ap_continue(ap_continue),
        .finish(finish),
        .state(state),
        .cycle_cnt(cycle_cnt),
        .start_cnt(start_cnt),
        .done_cnt(done_cnt),
        .outstanding(outstanding),
        .last_latency(last_latency),
        .min_latency(min_latency),
        .max_latency(max_latency),
        .last_interval(last_interval),
        .stall_cnt(stall_cnt),
        .overflow(overflow),
        .underflow(underflow),
        .finished(finished)
    );

    // Free-running clock, period 10
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive one cycle of inputs, then step past the next rising edge before sampling
    task automatic applyStimulus(input logic r, input logic s, input logic rd, input logic d,
                                 input logic c, input logic f);
        reset       = r;
        ap_start    = s;
        ap_ready    = rd;
        ap_done     = d;
        ap_continue = c;
        finish      = f;
        @(posedge clock);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Check every output against one table row
    task automatic checkRow(input int idx, input vec_t v);
        checkOutput($sformatf("row%0d state", idx), 32'(state), v.eSt);
        checkOutput($sformatf("row%0d cycle_cnt", idx), cycle_cnt, v.eCyc);
        checkOutput($sformatf("row%0d start_cnt", idx), start_cnt, v.eSc);
        checkOutput($sformatf("row%0d done_cnt", idx), done_cnt, v.eDc);
        checkOutput($sformatf("row%0d outstanding", idx), 32'(outstanding), v.eOut);
        checkOutput($sformatf("row%0d last_latency", idx), last_latency, v.eLast);
        checkOutput($sformatf("row%0d min_latency", idx), min_latency, v.eMin);
        checkOutput($sformatf("row%0d max_latency", idx), max_latency, v.eMax);
        checkOutput($sformatf("row%0d last_interval", idx), last_interval, v.eInt);
        checkOutput($sformatf("row%0d stall_cnt", idx), stall_cnt, v.eStall);
        checkOutput($sformatf("row%0d overflow", idx), 32'(overflow), v.eOvf);
        checkOutput($sformatf("row%0d underflow", idx), 32'(underflow), v.eUnf);
        checkOutput($sformatf("row%0d finished", idx), 32'(finished), v.eFin);
    endtask

    function automatic void addVec(input logic [31:0] rst, s, rd, d, c, f,
                                   eSt, eCyc, eSc, eDc, eOut, eLast, eMin, eMax, eInt,
                                   eStall, eOvf, eUnf, eFin);
        vecs.push_back('{rst, s, rd, d, c, f, eSt, eCyc, eSc, eDc, eOut, eLast, eMin, eMax,
                         eInt, eStall, eOvf, eUnf, eFin});
    endfunction

    task automatic resetDut();
        applyStimulus(1, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 1, 0);
    endtask

    initial begin
        // Columns: rst start ready done cont finish | state cycle starts dones outst last min max interval stall ovf unf fin
        // Overflow with DEPTH=4, drain, then done on an empty FIFO
        addVec(1,0,0,0,1,0, 0,0,0,0,0,0,F,0,0,0,0,0,0);
        addVec(0,1,1,0,1,0, 1,1,1,0,1,0,F,0,0,0,0,0,0);
        addVec(0,1,1,0,1,0, 1,2,2,0,2,0,F,0,1,0,0,0,0);
        addVec(0,1,1,0,1,0, 1,3,3,0,3,0,F,0,1,0,0,0,0);
        addVec(0,1,1,0,1,0, 1,4,4,0,4,0,F,0,1,0,0,0,0);
        addVec(0,1,1,0,1,0, 1,5,5,0,4,0,F,0,1,0,1,0,0);
        addVec(0,0,0,1,1,0, 1,6,5,1,3,5,5,5,1,0,1,0,0);
        addVec(0,0,0,1,1,0, 1,7,5,2,2,5,5,5,1,0,1,0,0);
        addVec(0,0,0,1,1,0, 1,8,5,3,1,5,5,5,1,0,1,0,0);
        addVec(0,0,0,1,1,0, 0,9,5,4,0,5,5,5,1,0,1,0,0);
        addVec(0,0,0,1,1,0, 0,10,5,5,0,5,5,5,1,0,1,1,0);
        // Single transaction: start at cycle 2, done at cycle 7, then a stray ap_ready
        addVec(1,0,0,0,1,0, 0,0,0,0,0,0,F,0,0,0,0,0,0);
        addVec(0,0,0,0,1,0, 0,1,0,0,0,0,F,0,0,0,0,0,0);
        addVec(0,0,0,0,1,0, 0,2,0,0,0,0,F,0,0,0,0,0,0);
        addVec(0,1,1,0,1,0, 1,3,1,0,1,0,F,0,0,0,0,0,0);
        addVec(0,0,0,0,1,0, 1,4,1,0,1,0,F,0,0,0,0,0,0);
        addVec(0,0,0,0,1,0, 1,5,1,0,1,0,F,0,0,0,0,0,0);
        addVec(0,0,0,0,1,0, 1,6,1,0,1,0,F,0,0,0,0,0,0);
        addVec(0,0,0,0,1,0, 1,7,1,0,1,0,F,0,0,0,0,0,0);
        addVec(0,0,0,1,1,0, 0,8,1,1,0,5,5,5,0,0,0,0,0);
        addVec(0,0,1,0,1,0, 0,9,1,1,0,5,5,5,0,0,0,0,0);
        // Pipelined: starts at 1,4,6, dones at 9,12,15, then bypass and same-cycle pop/push
        addVec(1,0,0,0,1,0, 0,0,0,0,0,0,F,0,0,0,0,0,0);
        addVec(0,0,0,0,1,0, 0,1,0,0,0,0,F,0,0,0,0,0,0);
        addVec(0,1,1,0,1,0, 1,2,1,0,1,0,F,0,0,0,0,0,0);
        addVec(0,0,0,0,1,0, 1,3,1,0,1,0,F,0,0,0,0,0,0);
        addVec(0,0,0,0,1,0, 1,4,1,0,1,0,F,0,0,0,0,0,0);
        addVec(0,1,1,0,1,0, 1,5,2,0,2,0,F,0,3,0,0,0,0);
        addVec(0,0,0,0,1,0, 1,6,2,0,2,0,F,0,3,0,0,0,0);
        addVec(0,1,1,0,1,0, 1,7,3,0,3,0,F,0,2,0,0,0,0);
        addVec(0,0,0,0,1,0, 1,8,3,0,3,0,F,0,2,0,0,0,0);
        addVec(0,0,0,0,1,0, 1,9,3,0,3,0,F,0,2,0,0,0,0);
        addVec(0,0,0,1,1,0, 1,10,3,1,2,8,8,8,2,0,0,0,0);
        addVec(0,0,0,0,1,0, 1,11,3,1,2,8,8,8,2,0,0,0,0);
        addVec(0,0,0,0,1,0, 1,12,3,1,2,8,8,8,2,0,0,0,0);
        addVec(0,0,0,1,1,0, 1,13,3,2,1,8,8,8,2,0,0,0,0);
        addVec(0,0,0,0,1,0, 1,14,3,2,1,8,8,8,2,0,0,0,0);
        addVec(0,0,0,0,1,0, 1,15,3,2,1,8,8,8,2,0,0,0,0);
        addVec(0,0,0,1,1,0, 0,16,3,3,0,9,8,9,2,0,0,0,0);
        addVec(0,1,1,1,1,0, 1,17,4,4,0,0,0,9,10,0,0,0,0);
        addVec(0,1,1,0,1,0, 1,18,5,4,1,0,0,9,1,0,0,0,0);
        addVec(0,1,1,1,1,0, 1,19,6,5,1,1,0,9,1,0,0,0,0);
        addVec(0,0,0,1,1,0, 0,20,6,6,0,1,0,9,1,0,0,0,0);

        // Reset held 3 cycles, then 10 idle cycles with a stray ap_ready
        reset = 1'b1; ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
        ap_continue = 1'b1; finish = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("reset cycle_cnt", cycle_cnt, 0);
        checkOutput("reset state", 32'(state), 0);
        checkOutput("reset min_latency", min_latency, F);
        checkOutput("reset finished", 32'(finished), 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0, 1, 0);
        checkOutput("idle cycle_cnt", cycle_cnt, 10);
        checkOutput("idle start_cnt", start_cnt, 0);
        checkOutput("idle state", 32'(state), 0);
        checkOutput("idle min_latency", min_latency, F);
        checkOutput("idle outstanding", 32'(outstanding), 0);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst[0], vecs[i].s[0], vecs[i].rd[0], vecs[i].d[0],
                          vecs[i].c[0], vecs[i].f[0]);
            checkRow(i, vecs[i]);
        end

        // Stall: done held for 4 cycles with continue low, then released
        resetDut();
        applyStimulus(0, 1, 1, 0, 1, 0);
        checkOutput("stall pre start_cnt", start_cnt, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 0);
            checkOutput($sformatf("stall%0d state", i), 32'(state), 2);
            checkOutput($sformatf("stall%0d stall_cnt", i), stall_cnt, 32'(i + 1));
            checkOutput($sformatf("stall%0d done_cnt", i), done_cnt, 0);
        end
        applyStimulus(0, 0, 0, 1, 1, 0);
        checkOutput("stall release state", 32'(state), 0);
        checkOutput("stall release done_cnt", done_cnt, 1);
        checkOutput("stall release stall_cnt", stall_cnt, 4);
        checkOutput("stall release last_latency", last_latency, 5);

        // Finish at cycle 20 with a start in the same cycle, then inputs are ignored
        resetDut();
        applyStimulus(0, 1, 1, 0, 1, 0);
        for (int i = 0; i < 19; i++) applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("prefinish cycle_cnt", cycle_cnt, 20);
        applyStimulus(0, 1, 1, 0, 1, 1);
        checkOutput("finish state", 32'(state), 3);
        checkOutput("finish finished", 32'(finished), 1);
        checkOutput("finish cycle_cnt", cycle_cnt, 21);
        checkOutput("finish start_cnt", start_cnt, 2);
        checkOutput("finish last_interval", last_interval, 20);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 1, 1, 0);
        checkOutput("frozen state", 32'(state), 3);
        checkOutput("frozen cycle_cnt", cycle_cnt, 21);
        checkOutput("frozen start_cnt", start_cnt, 2);
        checkOutput("frozen done_cnt", done_cnt, 0);
        checkOutput("frozen outstanding", 32'(outstanding), 2);
        checkOutput("frozen min_latency", min_latency, F);
        checkOutput("frozen finished", 32'(finished), 1);
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("post reset state", 32'(state), 0);
        checkOutput("post reset cycle_cnt", cycle_cnt, 0);
        checkOutput("post reset start_cnt", start_cnt, 0);
        checkOutput("post reset outstanding", 32'(outstanding), 0);
        checkOutput("post reset min_latency", min_latency, F);
        checkOutput("post reset last_interval", last_interval, 0);
        checkOutput("post reset finished", 32'(finished), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
